// File: rtl/match_sequencer_if.sv
// Move handshake and board-register bus between match_sequencer, the two
// requesters and the position registers.
interface match_sequencer_if;
    logic       pl_req;
    logic [3:0] pl_pos;
    logic       pl_ack;
    logic       pl_nack;
    logic       pc_req;
    logic [3:0] pc_pos;
    logic       pc_ack;
    logic       pc_nack;
    logic [8:0] occupied;
    logic       win;
    logic       no_space;
    logic       wr_en;
    logic [3:0] wr_pos;
    logic [1:0] wr_who;
    logic       board_clear;

    modport master (
        input  pl_req, pl_pos, pc_req, pc_pos, occupied, win, no_space,
        output pl_ack, pl_nack, pc_ack, pc_nack, wr_en, wr_pos, wr_who, board_clear
    );

    modport slave (
        output pl_req, pl_pos, pc_req, pc_pos, occupied, win, no_space,
        input  pl_ack, pl_nack, pc_ack, pc_nack, wr_en, wr_pos, wr_who, board_clear
    );
endinterface

// File: rtl/match_sequencer.sv
// Turn-and-match controller for tic-tac-toe: arbitrates player/computer moves,
// validates them against the board, and runs a best-of-N match with scores.
module match_sequencer #(
    parameter int unsigned MOVE_TIMEOUT    = 255,
    parameter int unsigned GAMES_PER_MATCH = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    match_sequencer_if.master   bus,
    output logic [1:0]          turn,
    output logic [3:0]          pl_score,
    output logic [3:0]          pc_score,
    output logic [3:0]          draws,
    output logic [3:0]          game_cnt,
    output logic                match_done,
    output logic [1:0]          match_winner
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] CLEAR      = 3'd1;
    localparam logic [2:0] WAIT_MOVE  = 3'd2;
    localparam logic [2:0] WRITE      = 3'd3;
    localparam logic [2:0] REJECT     = 3'd4;
    localparam logic [2:0] CHECK      = 3'd5;
    localparam logic [2:0] GAME_END   = 3'd6;
    localparam logic [2:0] MATCH_DONE = 3'd7;

    localparam logic [15:0] TIMEOUT_LAST = 16'(MOVE_TIMEOUT - 1);
    localparam logic [3:0]  GAMES        = 4'(GAMES_PER_MATCH);
    localparam logic [3:0]  MAJORITY     = 4'(GAMES_PER_MATCH / 2);

    localparam logic [1:0] WHO_PL = 2'b01;
    localparam logic [1:0] WHO_PC = 2'b10;

    logic [2:0]  state_q, state_d;
    logic        starter_q, starter_d;   // 0 player, 1 computer
    logic        mover_q, mover_d;       // side holding the current turn
    logic [15:0] timer_q, timer_d;
    logic [1:0]  turn_q, turn_d;
    logic [3:0]  pl_score_q, pl_score_d;
    logic [3:0]  pc_score_q, pc_score_d;
    logic [3:0]  draws_q, draws_d;
    logic [3:0]  game_cnt_q, game_cnt_d;
    logic        match_done_q, match_done_d;
    logic [1:0]  match_winner_q, match_winner_d;
    logic        wr_en_q, wr_en_d;
    logic [3:0]  wr_pos_q, wr_pos_d;
    logic [1:0]  wr_who_q, wr_who_d;
    logic        board_clear_q, board_clear_d;
    logic        pl_ack_q, pl_ack_d;
    logic        pl_nack_q, pl_nack_d;
    logic        pc_ack_q, pc_ack_d;
    logic        pc_nack_q, pc_nack_d;

    logic        req_sel;
    logic [3:0]  pos_sel;
    logic [15:0] occ_ext;
    logic        pos_bad;

    function automatic logic [1:0] side_code(input logic side);
        return side ? WHO_PC : WHO_PL;
    endfunction

    // Only the turn holder's request is looked at; the other side is ignored.
    assign req_sel = mover_q ? bus.pc_req : bus.pl_req;
    assign pos_sel = mover_q ? bus.pc_pos : bus.pl_pos;
    assign occ_ext = {7'd0, bus.occupied};
    assign pos_bad = (pos_sel > 4'd8) || occ_ext[pos_sel];

    always_comb begin
        state_d        = state_q;
        starter_d      = starter_q;
        mover_d        = mover_q;
        timer_d        = timer_q;
        turn_d         = turn_q;
        pl_score_d     = pl_score_q;
        pc_score_d     = pc_score_q;
        draws_d        = draws_q;
        game_cnt_d     = game_cnt_q;
        match_done_d   = match_done_q;
        match_winner_d = match_winner_q;
        wr_en_d        = 1'b0;
        wr_pos_d       = wr_pos_q;
        wr_who_d       = wr_who_q;
        board_clear_d  = 1'b0;
        pl_ack_d       = 1'b0;
        pl_nack_d      = 1'b0;
        pc_ack_d       = 1'b0;
        pc_nack_d      = 1'b0;

        case (state_q)
            IDLE, MATCH_DONE: begin
                if (start) begin
                    state_d        = CLEAR;
                    board_clear_d  = 1'b1;
                    starter_d      = 1'b0;
                    pl_score_d     = 4'd0;
                    pc_score_d     = 4'd0;
                    draws_d        = 4'd0;
                    game_cnt_d     = 4'd0;
                    match_done_d   = 1'b0;
                    match_winner_d = 2'b00;
                end
            end

            CLEAR: begin
                state_d = WAIT_MOVE;
                mover_d = starter_q;
                turn_d  = side_code(starter_q);
                timer_d = 16'd0;
            end

            WAIT_MOVE: begin
                if (req_sel) begin
                    if (pos_bad) begin
                        state_d   = REJECT;
                        pl_nack_d = ~mover_q;
                        pc_nack_d = mover_q;
                    end else begin
                        state_d  = WRITE;
                        wr_en_d  = 1'b1;
                        wr_pos_d = pos_sel;
                        wr_who_d = side_code(mover_q);
                        pl_ack_d = ~mover_q;
                        pc_ack_d = mover_q;
                        turn_d   = 2'b00;
                    end
                end else if (timer_q == TIMEOUT_LAST) begin
                    // Idle turn holder forfeits; opponent takes the game.
                    state_d = GAME_END;
                    turn_d  = 2'b00;
                    if (mover_q) pl_score_d = pl_score_q + 4'd1;
                    else         pc_score_d = pc_score_q + 4'd1;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            REJECT: state_d = WAIT_MOVE;

            WRITE: state_d = CHECK;

            CHECK: begin
                if (bus.win) begin
                    state_d = GAME_END;
                    if (wr_who_q == WHO_PL)      pl_score_d = pl_score_q + 4'd1;
                    else if (wr_who_q == WHO_PC) pc_score_d = pc_score_q + 4'd1;
                end else if (bus.no_space) begin
                    state_d = GAME_END;
                    draws_d = draws_q + 4'd1;
                end else begin
                    state_d = WAIT_MOVE;
                    mover_d = ~mover_q;
                    turn_d  = side_code(~mover_q);
                    timer_d = 16'd0;
                end
            end

            GAME_END: begin
                game_cnt_d = game_cnt_q + 4'd1;
                if ((game_cnt_d == GAMES) || (pl_score_q > MAJORITY) ||
                    (pc_score_q > MAJORITY)) begin
                    state_d      = MATCH_DONE;
                    match_done_d = 1'b1;
                    if (pl_score_q > pc_score_q)      match_winner_d = WHO_PL;
                    else if (pc_score_q > pl_score_q) match_winner_d = WHO_PC;
                    else                              match_winner_d = 2'b11;
                end else begin
                    state_d       = CLEAR;
                    board_clear_d = 1'b1;
                    starter_d     = ~starter_q;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            starter_q      <= 1'b0;
            mover_q        <= 1'b0;
            timer_q        <= 16'd0;
            turn_q         <= 2'b00;
            pl_score_q     <= 4'd0;
            pc_score_q     <= 4'd0;
            draws_q        <= 4'd0;
            game_cnt_q     <= 4'd0;
            match_done_q   <= 1'b0;
            match_winner_q <= 2'b00;
            wr_en_q        <= 1'b0;
            wr_pos_q       <= 4'd0;
            wr_who_q       <= 2'b00;
            board_clear_q  <= 1'b0;
            pl_ack_q       <= 1'b0;
            pl_nack_q      <= 1'b0;
            pc_ack_q       <= 1'b0;
            pc_nack_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            starter_q      <= starter_d;
            mover_q        <= mover_d;
            timer_q        <= timer_d;
            turn_q         <= turn_d;
            pl_score_q     <= pl_score_d;
            pc_score_q     <= pc_score_d;
            draws_q        <= draws_d;
            game_cnt_q     <= game_cnt_d;
            match_done_q   <= match_done_d;
            match_winner_q <= match_winner_d;
            wr_en_q        <= wr_en_d;
            wr_pos_q       <= wr_pos_d;
            wr_who_q       <= wr_who_d;
            board_clear_q  <= board_clear_d;
            pl_ack_q       <= pl_ack_d;
            pl_nack_q      <= pl_nack_d;
            pc_ack_q       <= pc_ack_d;
            pc_nack_q      <= pc_nack_d;
        end
    end

    assign bus.pl_ack      = pl_ack_q;
    assign bus.pl_nack     = pl_nack_q;
    assign bus.pc_ack      = pc_ack_q;
    assign bus.pc_nack     = pc_nack_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_pos      = wr_pos_q;
    assign bus.wr_who      = wr_who_q;
    assign bus.board_clear = board_clear_q;

    assign turn         = turn_q;
    assign pl_score     = pl_score_q;
    assign pc_score     = pc_score_q;
    assign draws        = draws_q;
    assign game_cnt     = game_cnt_q;
    assign match_done   = match_done_q;
    assign match_winner = match_winner_q;

endmodule

// File: doc/match_sequencer.md
# match_sequencer

Turn-and-match controller for the tic-tac-toe board. It arbitrates move requests between the player and computer requesters and validates each move against board occupancy. Accepted moves are written into the position registers, and the block reads back win/no-space status after every write. It runs a best-of-N match with alternating first mover, per-turn timeout, and running scores.

## Interface
Parameters:
- MOVE_TIMEOUT, 255: cycles a side may idle in its turn before forfeiting the game (1..65535).
- GAMES_PER_MATCH, 3: maximum games per match (1..15).

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clock.
- start  in  1  begin a new match; honoured only in IDLE or MATCH_DONE.
- pl_req  in  1  player move request; held until pl_ack or pl_nack.
- pl_pos  in  4  player target square 0..8; stable while pl_req high.
- pl_ack  out  1  one-cycle pulse: player move accepted.
- pl_nack  out  1  one-cycle pulse: player move rejected.
- pc_req, pc_pos, pc_ack, pc_nack: same as above, for the computer.
- occupied  in  9  bit i = square i non-empty (from position registers).
- win  in  1  three-in-a-row present on board.
- no_space  in  1  all nine squares occupied.
- wr_en  out  1  one-cycle board write strobe.
- wr_pos  out  4  square written (0..8), valid with wr_en.
- wr_who  out  2  01 player, 10 computer, valid with wr_en.
- board_clear  out  1  one-cycle pulse clearing all position registers.
- turn  out  2  01 player to move, 10 computer to move, 00 otherwise.
- pl_score, pc_score, draws  out  4 each  match tallies.
- game_cnt  out  4  games completed in current match.
- match_done  out  1  high while in MATCH_DONE.
- match_winner  out  2  01 player, 10 computer, 11 tie, 00 until match done.

## Operation
- States: IDLE, CLEAR, WAIT_MOVE, WRITE, REJECT, CHECK, GAME_END, MATCH_DONE.
- IDLE: start=1 -> CLEAR. Scores, draws, game_cnt, and match_winner are zeroed on this transition. Starter is set to player.
- CLEAR: board_clear=1 for one cycle -> WAIT_MOVE. Turn is set to the starter, and the timer is set to 0.
- WAIT_MOVE: only the turn holder's req is examined; the other side's req is ignored (no ack/nack).
  - req with pos>8 or occupied[pos]=1 -> REJECT.
  - Valid req -> WRITE; wr_pos/wr_who are latched.
  - No req: timer increments. If timer==MOVE_TIMEOUT-1 -> GAME_END, with the opponent credited a win.
  - A req in the same cycle as the timeout takes priority over the timeout.
- REJECT: nack pulse to the turn holder -> WAIT_MOVE. The timer holds and is not reset.
- WRITE: wr_en=1 and ack pulse to the turn holder -> CHECK.
- CHECK (board now updated):
  - win=1 -> mover's score +1 -> GAME_END.
  - Else no_space=1 -> draws+1 -> GAME_END.
  - Else turn swaps, timer=0 -> WAIT_MOVE.
- GAME_END: game_cnt+1.
  - Match is over if game_cnt (new value) == GAMES_PER_MATCH, or if either score > GAMES_PER_MATCH/2 (integer division). Then -> MATCH_DONE, and match_winner = higher score, or 11 if equal.
  - Otherwise the starter toggles -> CLEAR.
- MATCH_DONE: all tallies are held. start=1 -> CLEAR, with tallies zeroed and starter=player.
- Credit goes to the latched mover (wr_who), not to the board's winner code.

## Timing
- All outputs are registered.
- Reset (any state, mid-game included) zeroes every output at the next edge and moves to IDLE. board_clear is not pulsed on reset; the board has its own reset.
- Reset has priority over start and req.
- start sampled at cycle t:
  - board_clear high at t+1.
  - turn valid at t+2.
- Valid req sampled at t (WAIT_MOVE):
  - ack, wr_en, wr_pos, and wr_who at t+1.
  - CHECK at t+2.
  - Next turn at t+3 (turn=00 during t+1..t+2).
- Invalid req at t: nack at t+1, and req is re-examined from t+2. A requester that keeps req high gets a nack every 2 cycles.
- Timeout: with the timer starting at 0 and no req, GAME_END is entered MOVE_TIMEOUT cycles after WAIT_MOVE entry.
- req is ignored outside WAIT_MOVE. start is ignored outside IDLE and MATCH_DONE.

## Test plan
- Player moves 0,1,2 and computer moves 3,4, GAMES_PER_MATCH=3 -> after the third player write, pl_score=1 and game_cnt=1. board_clear pulses, and turn=10 (computer starts game 2).
- Player req pos 4 while occupied[4]=1 -> pl_nack one cycle and no wr_en. A retry with pos 5 -> pl_ack and wr_en with wr_pos=5, wr_who=01.
- Board fill with no line -> draws=1. A best-of-3 with results draw, player, player -> match_done=1, match_winner=01, game_cnt=3.
- MOVE_TIMEOUT=8, computer's turn, no req -> GAME_END 8 cycles after WAIT_MOVE entry, pl_score+1.
- pc_req asserted during the player's turn -> no pc_ack/pc_nack. Simultaneous pl_req and pc_req -> only the player's move is written.
- reset pulsed in WRITE -> next cycle all outputs 0 and state IDLE. A following start begins with starter=player and tallies 0.
